vex_wb_buffer: RTL and testbench
================================

Name: vex_wb_buffer

Overview:
- Writeback buffer directly downstream of the vector execution pipe.
- Accepts one result per cycle: data, scalar/vector flag, destination register, element index.
- Queues results in an in-order FIFO and drains the head either to the vector register-file write port or to the scalar-core result port.
- Absorbs cycles where the VRF port is taken by another unit or the scalar core stalls; applies backpressure to issue through ready_o.

Parameters:
- DATA_WIDTH, 32, result data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- VREG_W, 5, vector destination register index width.
- ELEM_W, 3, element index width (log2 of VECTOR_LANES = 8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all queued entries.
- valid_i  in  1  result valid from execution pipe.
- ready_o  out  1  buffer can accept a result this cycle.
- data_i  in  DATA_WIDTH  result data.
- scalar_i  in  1  result targets the scalar register file.
- vd_i  in  VREG_W  vector destination register.
- elem_i  in  ELEM_W  element index.
- vrf_wr_en_o  out  1  VRF write request.
- vrf_wr_ready_i  in  1  VRF port granted this cycle.
- vrf_wr_addr_o  out  VREG_W  VRF destination register.
- vrf_wr_elem_o  out  ELEM_W  VRF element index.
- vrf_wr_data_o  out  DATA_WIDTH  VRF write data.
- scl_valid_o  out  1  scalar result valid.
- scl_ready_i  in  1  scalar core accepts the result.
- scl_data_o  out  DATA_WIDTH  scalar result data.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky error: valid_i was asserted while ready_o was low.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Read/write pointers = 0, count = 0, overflow_o = 0.
  - ready_o = 1; vrf_wr_en_o = 0; scl_valid_o = 0.
  - Entry storage is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is a separate register from 0 to DEPTH.
- ready_o = (count < DEPTH). It depends only on registered state, with no combinational path from vrf_wr_ready_i or scl_ready_i.
- Push = valid_i & ready_o & ~flush_i. It writes {data_i, scalar_i, vd_i, elem_i} at wr_ptr; wr_ptr increments.
- valid_i & ~ready_o: the result is dropped, no state changes, and overflow_o sets on the next edge. It clears only on reset.
- Head outputs are driven from storage at rd_ptr, gated by count != 0.
  - vrf_wr_en_o = nonempty & ~head.scalar.
  - scl_valid_o = nonempty & head.scalar.
  - Address, element and data outputs are valid only while the corresponding enable/valid is high.
- Pop = (vrf_wr_en_o & vrf_wr_ready_i) | (scl_valid_o & scl_ready_i); rd_ptr increments.
- Ordering is strictly in-order: a scalar head blocks later vector entries and vice versa.
- Latency: a result pushed at edge N appears at the head no earlier than the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - Legal at any occupancy from 1 to DEPTH-1.
  - Push is impossible at DEPTH (ready_o = 0). Pop is impossible at 0.
- Output stability: while a head is presented and not accepted, its enable, address, element and data hold stable.
- flush_i has priority over push and pop. On the next edge, pointers and count clear to 0 and no write is issued that cycle.
  - Head enables are still driven during the flush cycle, but any pop occurring then is discarded together with the flush.
  - overflow_o is unaffected by flush_i.
- Reset asserted mid-drain: all outputs deassert immediately (asynchronous) and all queued entries are lost.

Decomposition:
- Shared vector package gets:
  - wb_entry_t typedef: data, scalar, vd, elem.
  - Default VREG_W / ELEM_W constants, alongside the existing to_vector_alu typedef.
- One sub-module is natural: vwb_fifo.
  - Generic storage, pointers and count; parameterised by DEPTH and entry type.
  - Exports full, empty, head entry, count.
  - Port routing, pop selection and overflow_o stay in vex_wb_buffer.

Test Plan:
1. Reset, then 3 vector pushes (data 0x11, 0x22, 0x33; vd 5; elem 0, 1, 2) with vrf_wr_ready_i = 1 -> vrf_wr_en_o high for 3 consecutive cycles starting one cycle after the first push. Data appears in order, scl_valid_o stays 0, count_o returns to 0.
2. vrf_wr_ready_i = 0, push 4 entries -> count_o = 4, ready_o = 0. A 5th valid_i sets overflow_o = 1 and that entry never appears. Releasing vrf_wr_ready_i drains exactly 4 entries in order.
3. Mixed order: vector 0xA0, scalar 0xB0, vector 0xC0; scl_ready_i = 0 for 3 cycles -> 0xA0 writes, scl_valid_o holds 0xB0 stable with vrf_wr_en_o = 0 for 3 cycles, then 0xB0 pops and 0xC0 writes.
4. count_o = 3 with continuous push and pop for 10 cycles -> count_o stays 3, data order preserved across pointer wrap (wr_ptr wraps at least twice).
5. Queue 3 entries, assert flush_i together with valid_i -> next cycle count_o = 0, no enables asserted, flushed/pushed data never written, overflow_o unchanged.
6. Assert rst_n low asynchronously mid-drain (count_o = 2) -> vrf_wr_en_o and scl_valid_o drop without a clock edge; after release count_o = 0, ready_o = 1.

Source files
------------

// File: rtl/vex_wb_buffer_pkg.sv
// Shared vector-unit types: ALU issue bundle and writeback entry layout.
// No logic; constants and typedefs only.
// Default widths match an 8-lane, 32-register vector unit.
package vex_wb_buffer_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int VREG_W_DEF  = 5;
   localparam int VEC_LANES   = 8;
   localparam int ELEM_W_DEF  = $clog2(VEC_LANES);

   // Operation bundle handed from issue to the vector ALU.
   typedef struct packed {
      logic [3:0]            op;
      logic [DATA_W_DEF-1:0] opa;
      logic [DATA_W_DEF-1:0] opb;
      logic [VREG_W_DEF-1:0] vd;
      logic [ELEM_W_DEF-1:0] elem;
   } to_vector_alu_t;

   // One queued result at default widths.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  scalar;
      logic [VREG_W_DEF-1:0] vd;
      logic [ELEM_W_DEF-1:0] elem;
   } wb_entry_t;

endpackage

// File: rtl/vex_wb_buffer_fifo.sv
// Generic in-order FIFO: storage, wrapping pointers and a separate occupancy count.
// Latency: a push at edge N is visible at head_o after edge N; no write-through bypass.
// Backpressure: caller must not push while full_o or pop while empty_o; clr_i beats both.
module vwb_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0],
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          push_i,
   input  entry_t        wdat_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output entry_t        head_o,
   output logic [CW-1:0] count_o
);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // A clear swallows any push or pop issued in the same cycle.
   assign do_push = push_i & ~clr_i;
   assign do_pop  = pop_i & ~clr_i;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; storage contents are deliberately not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry write at the tail.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdat_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/vex_wb_buffer.sv
// Writeback buffer: queues vector-pipe results in order, drains head to VRF or scalar core.
// Latency: result pushed at edge N is presented at the head from the cycle after edge N.
// Backpressure: ready_o = not full (registered only); sink stalls hold the head stable.
module vex_wb_buffer
   import vex_wb_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int DEPTH      = 4,
   parameter int VREG_W     = VREG_W_DEF,
   parameter int ELEM_W     = ELEM_W_DEF,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  scalar_i,
   input  logic [VREG_W-1:0]     vd_i,
   input  logic [ELEM_W-1:0]     elem_i,
   output logic                  vrf_wr_en_o,
   input  logic                  vrf_wr_ready_i,
   output logic [VREG_W-1:0]     vrf_wr_addr_o,
   output logic [ELEM_W-1:0]     vrf_wr_elem_o,
   output logic [DATA_WIDTH-1:0] vrf_wr_data_o,
   output logic                  scl_valid_o,
   input  logic                  scl_ready_i,
   output logic [DATA_WIDTH-1:0] scl_data_o,
   output logic [CW-1:0]         count_o,
   output logic                  overflow_o
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  scalar;
      logic [VREG_W-1:0]     vd;
      logic [ELEM_W-1:0]     elem;
   } entry_t;

   entry_t wdat, head;
   logic   full, empty, push, pop;
   logic   overflow_q, overflow_d;

   assign ready_o = ~full;
   assign push    = valid_i & ready_o & ~flush_i;
   assign wdat    = '{data: data_i, scalar: scalar_i, vd: vd_i, elem: elem_i};

   vwb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush_i),
      .push_i  (push),
      .wdat_i  (wdat),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head),
      .count_o (count_o)
   );

   // Head routing: scalar entries go to the core, everything else to the VRF.
   assign vrf_wr_en_o   = ~empty & ~head.scalar;
   assign scl_valid_o   = ~empty &  head.scalar;
   assign vrf_wr_addr_o = head.vd;
   assign vrf_wr_elem_o = head.elem;
   assign vrf_wr_data_o = head.data;
   assign scl_data_o    = head.data;
   assign pop           = (vrf_wr_en_o & vrf_wr_ready_i) | (scl_valid_o & scl_ready_i);

   // Sticky overflow: a result offered while full is lost; flush does not clear it.
   always_comb begin
      overflow_d = overflow_q | (valid_i & ~ready_o);
   end

   // Overflow flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_vex_wb_buffer.sv
module tb_vex_wb_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i, valid_i, scalar_i;
   logic [31:0] data_i;
   logic [4:0]  vd_i;
   logic [2:0]  elem_i;
   logic        ready_o, vrf_wr_en_o, vrf_wr_ready_i, scl_valid_o, scl_ready_i, overflow_o;
   logic [4:0]  vrf_wr_addr_o;
   logic [2:0]  vrf_wr_elem_o;
   logic [31:0] vrf_wr_data_o, scl_data_o;
   logic [2:0]  count_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vex_wb_buffer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_i        (flush_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .data_i         (data_i),
      .scalar_i       (scalar_i),
      .vd_i           (vd_i),
      .elem_i         (elem_i),
      .vrf_wr_en_o    (vrf_wr_en_o),
      .vrf_wr_ready_i (vrf_wr_ready_i),
      .vrf_wr_addr_o  (vrf_wr_addr_o),
      .vrf_wr_elem_o  (vrf_wr_elem_o),
      .vrf_wr_data_o  (vrf_wr_data_o),
      .scl_valid_o    (scl_valid_o),
      .scl_ready_i    (scl_ready_i),
      .scl_data_o     (scl_data_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one full cycle; inputs set before, outputs sampled after (on negedge).
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d,
                        input logic [4:0] vd, input logic [2:0] e);
      valid_i  = v;
      scalar_i = s;
      data_i   = d;
      vd_i     = vd;
      elem_i   = e;
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; vrf_wr_ready_i = 1'b0; scl_ready_i = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      tick(); tick();
      check("rst_count", count_o, 0);
      check("rst_ready", ready_o, 1);
      check("rst_vrf_en", vrf_wr_en_o, 0);
      check("rst_scl_vld", scl_valid_o, 0);
      check("rst_ovf", overflow_o, 0);
      rst_n = 1'b1;
      tick();

      // 1: three vector pushes streaming straight to the VRF
      vrf_wr_ready_i = 1'b1;
      drive(1'b1, 1'b0, 32'h11, 5'd5, 3'd0);
      check("t1_no_bypass", vrf_wr_en_o, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("t1_en", vrf_wr_en_o, 1);
         check("t1_data", vrf_wr_data_o, 32'h11 * (i + 1));
         check("t1_elem", vrf_wr_elem_o, i);
         check("t1_addr", vrf_wr_addr_o, 5);
         check("t1_scl", scl_valid_o, 0);
         check("t1_count", count_o, 1);
         if (i < 2) drive(1'b1, 1'b0, 32'h11 * (i + 2), 5'd5, 3'(i + 1));
         else       drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
         tick();
      end
      check("t1_en_off", vrf_wr_en_o, 0);
      check("t1_count_end", count_o, 0);

      // 2: fill while VRF busy, overflow on 5th, drain 4
      vrf_wr_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h40 + i, 5'd7, 3'(i));
         tick();
      end
      check("t2_count_full", count_o, 4);
      check("t2_ready_low", ready_o, 0);
      check("t2_ovf_before", overflow_o, 0);
      drive(1'b1, 1'b0, 32'h99, 5'd9, 3'd7);
      tick();
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      check("t2_ovf_set", overflow_o, 1);
      check("t2_count_hold", count_o, 4);
      vrf_wr_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t2_en", vrf_wr_en_o, 1);
         check("t2_data", vrf_wr_data_o, 32'h40 + i);
         check("t2_elem", vrf_wr_elem_o, i);
         tick();
      end
      check("t2_empty", count_o, 0);
      check("t2_en_off", vrf_wr_en_o, 0);

      // 3: scalar head blocks the following vector entry
      scl_ready_i = 1'b0;
      drive(1'b1, 1'b0, 32'hA0, 5'd1, 3'd0);
      tick();
      check("t3_a0", vrf_wr_data_o, 32'hA0);
      check("t3_a0_en", vrf_wr_en_o, 1);
      drive(1'b1, 1'b1, 32'hB0, 5'd2, 3'd1);
      tick();
      drive(1'b1, 1'b0, 32'hC0, 5'd3, 3'd2);
      check("t3_b0_count", count_o, 1);
      for (int i = 0; i < 3; i++) begin
         check("t3_b0_vld", scl_valid_o, 1);
         check("t3_b0_data", scl_data_o, 32'hB0);
         check("t3_b0_vrf_off", vrf_wr_en_o, 0);
         tick();
         drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      end
      check("t3_count2", count_o, 2);
      scl_ready_i = 1'b1;
      tick();
      scl_ready_i = 1'b0;
      check("t3_c0_en", vrf_wr_en_o, 1);
      check("t3_c0_data", vrf_wr_data_o, 32'hC0);
      check("t3_c0_addr", vrf_wr_addr_o, 3);
      check("t3_scl_off", scl_valid_o, 0);
      tick();
      check("t3_empty", count_o, 0);

      // 4: steady push+pop at occupancy 3 across pointer wraps
      vrf_wr_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h50 + i, 5'd4, 3'(i));
         tick();
      end
      vrf_wr_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("t4_count", count_o, 3);
         check("t4_data", vrf_wr_data_o, 32'h50 + i);
         drive(1'b1, 1'b0, 32'h53 + i, 5'd4, 3'(i + 3));
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         check("t4_tail", vrf_wr_data_o, 32'h5A + i);
         tick();
      end
      check("t4_empty", count_o, 0);

      // 5: flush with a concurrent push
      vrf_wr_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h60 + i, 5'd6, 3'(i));
         tick();
      end
      check("t5_count3", count_o, 3);
      flush_i = 1'b1;
      drive(1'b1, 1'b0, 32'h77, 5'd6, 3'd5);
      tick();
      flush_i = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      check("t5_count0", count_o, 0);
      check("t5_en_off", vrf_wr_en_o, 0);
      check("t5_scl_off", scl_valid_o, 0);
      check("t5_ready", ready_o, 1);
      check("t5_ovf_kept", overflow_o, 1);
      vrf_wr_ready_i = 1'b1;
      tick();
      check("t5_still_off", vrf_wr_en_o, 0);
      drive(1'b1, 1'b0, 32'h88, 5'd8, 3'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      check("t5_fresh_data", vrf_wr_data_o, 32'h88);
      check("t5_fresh_count", count_o, 1);
      tick();

      // 6: asynchronous reset while two entries are queued
      vrf_wr_ready_i = 1'b0; scl_ready_i = 1'b0;
      drive(1'b1, 1'b1, 32'h90, 5'd1, 3'd0);
      tick();
      drive(1'b1, 1'b0, 32'h91, 5'd2, 3'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
      check("t6_count2", count_o, 2);
      check("t6_scl_on", scl_valid_o, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_scl", scl_valid_o, 0);
      check("t6_async_vrf", vrf_wr_en_o, 0);
      check("t6_async_count", count_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_count_after", count_o, 0);
      check("t6_ready_after", ready_o, 1);
      check("t6_ovf_after", overflow_o, 0);
      check("t6_en_after", vrf_wr_en_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
